// File: rtl/cpu_irq_controller.sv
// CPU interrupt source: synchronises request lines, latches pending, masks, fixed-priority arbitrates.
// One registered request with cause code, held until ack, then blocked until end-of-interrupt.
module cpu_irq_controller #(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [NUM_IRQ-1:0] LEVEL_MASK = '0,
  parameter logic [7:0]         CAUSE_BASE = 8'h10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               reg_we,
  input  logic [1:0]         reg_sel,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq_req,
  output logic [7:0]         irq_cause,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               in_service
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, soft_q, soft_d, enable_q, enable_d;
  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               irq_req_q, irq_req_d, in_service_q, in_service_d;
  logic [7:0]         irq_cause_q, irq_cause_d;

  logic [NUM_IRQ-1:0] pending, active, wmask, w1c, swi, ack_clr;
  logic [IW-1:0]      win_idx;
  logic               ack_fire, eoi_fire;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata[31:NUM_IRQ];
  assign wmask        = reg_wdata[NUM_IRQ-1:0];

  always_comb begin
    sync1_d  = irq_lines;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;

    // Edge lines live in pend_q; level lines are the synced level plus the sticky soft bit.
    pending  = (pend_q & ~LEVEL_MASK) | ((sync2_q | soft_q) & LEVEL_MASK);
    active   = pending & enable_q;

    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) win_idx = IW'(i);
    end

    w1c      = (reg_we && reg_sel == 2'd1) ? wmask : '0;
    swi      = (reg_we && reg_sel == 2'd3) ? wmask : '0;
    enable_d = (reg_we && reg_sel == 2'd0) ? wmask : enable_q;

    ack_fire = (state_q == REQ) && irq_ack && !stall;
    eoi_fire = (state_q == SERVICE) && irq_eoi && !stall;

    ack_clr = '0;
    if (ack_fire) ack_clr[idx_q] = 1'b1;

    // Clears first, then sets, so a fresh edge in the same cycle keeps the bit pending.
    pend_d = (((pend_q & ~w1c) & ~ack_clr) | (sync2_q & ~prev_q) | swi) & ~LEVEL_MASK;
    soft_d = ((soft_q & ~w1c) | swi) & LEVEL_MASK;

    state_d      = state_q;
    idx_d        = idx_q;
    irq_req_d    = irq_req_q;
    irq_cause_d  = irq_cause_q;
    in_service_d = in_service_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          state_d     = REQ;
          idx_d       = win_idx;
          irq_req_d   = 1'b1;
          irq_cause_d = CAUSE_BASE + 8'(win_idx);
        end
      end
      REQ: begin
        if (ack_fire) begin
          state_d      = SERVICE;
          irq_req_d    = 1'b0;
          in_service_d = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi_fire) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pend_q       <= '0;
      soft_q       <= '0;
      enable_q     <= '0;
      state_q      <= IDLE;
      idx_q        <= '0;
      irq_req_q    <= 1'b0;
      irq_cause_q  <= 8'h00;
      in_service_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      pend_q       <= pend_d;
      soft_q       <= soft_d;
      enable_q     <= enable_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      irq_req_q    <= irq_req_d;
      irq_cause_q  <= irq_cause_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    case (reg_sel)
      2'd0:    reg_rdata = 32'(enable_q);
      2'd1:    reg_rdata = 32'(pending);
      2'd2:    reg_rdata = 32'(irq_cause_q);
      default: reg_rdata = 32'h0;
    endcase
  end

  assign irq_req    = irq_req_q;
  assign irq_cause  = irq_cause_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_cpu_irq_controller.sv
// Directed self-checking bench for cpu_irq_controller with default parameters (8 edge lines, base 8'h10).
module tb_cpu_irq_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [7:0]  irq_lines;
  logic        reg_we;
  logic [1:0]  reg_sel;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_req;
  logic [7:0]  irq_cause;
  logic        irq_ack;
  logic        irq_eoi;
  logic        in_service;

  int n_checks = 0;
  int n_fails  = 0;

  cpu_irq_controller dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .irq_lines  (irq_lines),
    .reg_we     (reg_we),
    .reg_sel    (reg_sel),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .in_service (in_service)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    reg_we    = 1'b1;
    reg_sel   = sel;
    reg_wdata = data;
    tick();
    reg_we    = 1'b0;
    reg_wdata = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    reg_sel = sel;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic pulse(input logic [7:0] lines);
    irq_lines = lines;
    tick();
    irq_lines = 8'h00;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; irq_lines = 8'h00; reg_we = 1'b0;
    reg_sel = 2'd0; reg_wdata = 32'h0; irq_ack = 1'b0; irq_eoi = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_req", 32'(irq_req), 32'h0);
    check("rst_cause", 32'(irq_cause), 32'h0);
    check("rst_insvc", 32'(in_service), 32'h0);
    rd("rst_ienable", 2'd0, 32'h0);
    rd("rst_ipending", 2'd1, 32'h0);

    // Single edge on line 2: request four edges after the line rises
    wr(2'd0, 32'h04);
    pulse(8'h04);            // edge N+1
    ticks(2);                // edge N+3
    check("t1_req_n3", 32'(irq_req), 32'h0);
    rd("t1_pend_n3", 2'd1, 32'h04);
    tick();                  // edge N+4
    check("t1_req_n4", 32'(irq_req), 32'h1);
    check("t1_cause", 32'(irq_cause), 32'h12);
    rd("t1_icause", 2'd2, 32'h12);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t1_req_ack", 32'(irq_req), 32'h0);
    check("t1_insvc", 32'(in_service), 32'h1);
    rd("t1_pend_ack", 2'd1, 32'h0);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    check("t1_insvc_eoi", 32'(in_service), 32'h0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t1_ack_idle_ignored", 32'(in_service), 32'h0);
    check("t1_no_req", 32'(irq_req), 32'h0);

    // Lines 5 and 1 together: lowest index first; ack+eoi together takes ack only
    wr(2'd0, 32'hFF);
    pulse(8'h22);
    ticks(3);
    check("t2_req", 32'(irq_req), 32'h1);
    check("t2_cause1", 32'(irq_cause), 32'h11);
    irq_ack = 1'b1; irq_eoi = 1'b1; tick(); irq_ack = 1'b0; irq_eoi = 1'b0;
    check("t2_ack_eoi_insvc", 32'(in_service), 32'h1);
    rd("t2_pend_after_ack", 2'd1, 32'h20);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    check("t2_eoi_req_low", 32'(irq_req), 32'h0);
    tick();
    check("t2_req5", 32'(irq_req), 32'h1);
    check("t2_cause5", 32'(irq_cause), 32'h15);

    // Ack held under stall is ignored
    stall = 1'b1; irq_ack = 1'b1;
    ticks(3);
    check("t3_req_stalled", 32'(irq_req), 32'h1);
    check("t3_insvc_stalled", 32'(in_service), 32'h0);
    stall = 1'b0;
    tick(); irq_ack = 1'b0;
    check("t3_req_unstall", 32'(irq_req), 32'h0);
    check("t3_insvc_unstall", 32'(in_service), 32'h1);

    // New edge during SERVICE waits for eoi
    pulse(8'h08);
    ticks(4);
    check("t4_req_blocked", 32'(irq_req), 32'h0);
    rd("t4_pend", 2'd1, 32'h08);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    check("t4_req_at_eoi", 32'(irq_req), 32'h0);
    check("t4_insvc_eoi", 32'(in_service), 32'h0);
    tick();
    check("t4_req", 32'(irq_req), 32'h1);
    check("t4_cause", 32'(irq_cause), 32'h13);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;

    // Software interrupt on bit 7, then W1C racing a fresh edge on line 7
    wr(2'd0, 32'h80);
    wr(2'd3, 32'h80);
    check("t5_req_swi_edge", 32'(irq_req), 32'h0);
    rd("t5_pend_swi", 2'd1, 32'h80);
    tick();
    check("t5_req", 32'(irq_req), 32'h1);
    check("t5_cause", 32'(irq_cause), 32'h17);
    pulse(8'h80);            // edge M+1
    tick();                  // edge M+2
    wr(2'd1, 32'h80);        // edge M+3: rise and W1C coincide
    rd("t5_set_wins", 2'd1, 32'h80);
    wr(2'd1, 32'h80);
    rd("t5_w1c_clears", 2'd1, 32'h0);
    check("t5_req_frozen", 32'(irq_req), 32'h1);
    check("t5_cause_frozen", 32'(irq_cause), 32'h17);
    wr(2'd2, 32'h55);
    rd("t5_icause_ro", 2'd2, 32'h17);

    // Reset while in REQ
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_req", 32'(irq_req), 32'h0);
    check("t6_insvc", 32'(in_service), 32'h0);
    check("t6_cause", 32'(irq_cause), 32'h0);
    rd("t6_ienable", 2'd0, 32'h0);
    rd("t6_ipending", 2'd1, 32'h0);
    tick();
    check("t6_req_after", 32'(irq_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
